// File: rtl/plot_sweep_ctrl_pkg.sv
// Shared definitions for the redraw sequencer: FSM encoding, default screen
// geometry, default colours and the x/y field layout inside the counter value.
package plot_sweep_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ZERO  = 3'd2,
      S_PLOT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int DEF_X_MAX = 160;
   localparam int DEF_Y_MAX = 120;

   localparam logic [2:0] DEF_BG_COLOR = 3'b000;
   localparam logic [2:0] DEF_FG_COLOR = 3'b111;

   // Counter layout: x in [7:0], y in [14:8]
   localparam int X_LSB = 0;
   localparam int X_W   = 8;
   localparam int Y_LSB = 8;
   localparam int Y_W   = 7;

endpackage

// File: rtl/plot_sweep_ctrl_sweep_coord_decode.sv
// Splits the display counter value into pixel coordinates and derives the
// flags the sequencer needs: column on screen, last column, last clear pixel.
module sweep_coord_decode
   import plot_sweep_ctrl_pkg::*;
#(
   parameter int X_MAX = DEF_X_MAX,
   parameter int Y_MAX = DEF_Y_MAX,
   parameter int CNT_W = 18
) (
   input  logic [CNT_W-1:0] i_cnt_value,
   output logic [X_W-1:0]   o_x,
   output logic [Y_W-1:0]   o_y,
   output logic             o_x_in_range,
   output logic             o_x_last,
   output logic             o_clear_last
);

   // 9-bit limit so X_MAX = 256 still compares correctly
   localparam logic [X_W:0]   X_LIM  = 9'(X_MAX);
   localparam logic [X_W-1:0] X_LAST = 8'(X_MAX - 1);
   localparam logic [Y_W-1:0] Y_LAST = 7'(Y_MAX - 1);

   // Counter bits above the y field carry no coordinate information
   logic w_unused_hi;
   assign w_unused_hi = ^i_cnt_value[CNT_W-1:Y_LSB+Y_W];

   // Field extraction and flag generation
   always_comb begin
      o_x          = i_cnt_value[X_LSB +: X_W];
      o_y          = i_cnt_value[Y_LSB +: Y_W];
      o_x_in_range = ({1'b0, o_x} < X_LIM);
      o_x_last     = (o_x == X_LAST);
      o_clear_last = o_x_last && (o_y == Y_LAST);
   end

endmodule

// File: rtl/plot_sweep_ctrl.sv
// Redraw sequencer: clears the whole frame to the background colour by
// sweeping the external display counter, then walks every column through the
// polynomial evaluator handshake and strobes a foreground pixel per hit.
// All outputs are Mealy so pixel writes line up with cnt_value / eval_ack.
module plot_sweep_ctrl
   import plot_sweep_ctrl_pkg::*;
#(
   parameter int                 X_MAX    = DEF_X_MAX,
   parameter int                 Y_MAX    = DEF_Y_MAX,
   parameter int                 CNT_W    = 18,
   parameter int                 COLOR_W  = 3,
   parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR),
   parameter logic [COLOR_W-1:0] FG_COLOR = COLOR_W'(DEF_FG_COLOR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               cnt_enable,
   output logic               cnt_counting,
   input  logic [CNT_W-1:0]   cnt_value,
   output logic               eval_req,
   output logic [7:0]         eval_x,
   input  logic               eval_ack,
   input  logic [6:0]         eval_y,
   input  logic               eval_ok,
   output logic               plot,
   output logic [7:0]         plot_x,
   output logic [6:0]         plot_y,
   output logic [COLOR_W-1:0] plot_color
);

   state_t     r_state;
   state_t     w_next;

   logic [7:0] w_x;
   logic [6:0] w_y;
   logic       w_x_in_range;
   logic       w_x_last;
   logic       w_clear_last;

   sweep_coord_decode #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX),
      .CNT_W (CNT_W)
   ) u_decode (
      .i_cnt_value  (cnt_value),
      .o_x          (w_x),
      .o_y          (w_y),
      .o_x_in_range (w_x_in_range),
      .o_x_last     (w_x_last),
      .o_clear_last (w_clear_last)
   );

   // State register; reset returns to IDLE, which zeroes every output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and Mealy outputs; dropping cnt_enable clears the counter
   always_comb begin
      w_next       = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      cnt_enable   = 1'b0;
      cnt_counting = 1'b0;
      eval_req     = 1'b0;
      eval_x       = '0;
      plot         = 1'b0;
      plot_x       = '0;
      plot_y       = '0;
      plot_color   = '0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            busy       = 1'b1;
            cnt_enable = 1'b1;
            // Off-screen columns are swept silently
            if (w_x_in_range) begin
               plot       = 1'b1;
               plot_x     = w_x;
               plot_y     = w_y;
               plot_color = BG_COLOR;
            end
            // Hold on the last pixel so the counter is not pushed past it
            if (w_clear_last) w_next = S_ZERO;
            else              cnt_counting = 1'b1;
         end
         S_ZERO: begin
            busy   = 1'b1;
            w_next = S_PLOT;
         end
         S_PLOT: begin
            busy       = 1'b1;
            cnt_enable = 1'b1;
            eval_req   = 1'b1;
            eval_x     = w_x;
            if (eval_ack) begin
               if (eval_ok) begin
                  plot       = 1'b1;
                  plot_x     = w_x;
                  plot_y     = eval_y;
                  plot_color = FG_COLOR;
               end
               if (w_x_last) w_next = S_DONE;
               else          cnt_counting = 1'b1;
            end
         end
         S_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
